// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register / execution unit slice.
package instr_register_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned RESULT_W  = 64;
  localparam int unsigned ADDR_W    = 5;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic signed [RESULT_W-1:0]  result_t;
  typedef logic        [ADDR_W-1:0]    address_t;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  // One stored register entry as seen on the read port.
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  // Contents of one in-flight pipeline stage.
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    address_t addr;
  } stage_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational signed ALU producing a 64-bit result from two 32-bit operands.
module exec_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  result
);

  result_t w_a;
  result_t w_b;

  // Widen before any arithmetic so MULT gets the full product and the
  // most-negative / -1 division cannot overflow.
  assign w_a = {{(RESULT_W-OPERAND_W){op_a[OPERAND_W-1]}}, op_a};
  assign w_b = {{(RESULT_W-OPERAND_W){op_b[OPERAND_W-1]}}, op_b};

  // Select the operation; signed / and % truncate toward zero and give a
  // remainder that takes the dividend's sign. A zero divisor yields zero.
  always_comb begin
    result = '0;
    case (opc)
      ZERO:    result = '0;
      PASSA:   result = w_a;
      PASSB:   result = w_b;
      ADD:     result = w_a + w_b;
      SUB:     result = w_a - w_b;
      MULT:    result = w_a * w_b;
      DIV:     if (w_b != '0) result = w_a / w_b;
      MOD:     if (w_b != '0) result = w_a % w_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Register file of instruction entries with a two-stage result pipeline.
// A write stores the operands immediately and the result two edges later,
// unless a newer write to the same entry squashes the in-flight op.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  input  operand_t     operand_a,
  input  operand_t     operand_b,
  input  opcode_t      opcode,
  input  address_t     write_pointer,
  input  address_t     read_pointer,
  output instruction_t instruction_word,
  output logic         result_valid,
  output logic         busy
);

  // Only the two-stage pipeline is implemented.
  if (PIPE_STAGES != 2) begin : gUnsupportedDepth
    $error("instr_exec_unit supports PIPE_STAGES == 2 only");
  end

  instruction_t           r_entries [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_valid;

  logic    r_s1Valid;
  stage_t  r_s1;
  logic    r_s2Valid;
  stage_t  r_s2;

  logic    w_s1Squash;
  logic    w_writeback;
  result_t w_aluResult;

  // A new write to the address held in a stage kills that stage's op; this
  // also makes a new write win over a writeback landing on the same edge.
  assign w_s1Squash  = load_en && (r_s1.addr == write_pointer);
  assign w_writeback = r_s2Valid && !(load_en && (r_s2.addr == write_pointer));

  exec_alu uAlu (
    .opc    (r_s2.opc),
    .op_a   (r_s2.op_a),
    .op_b   (r_s2.op_b),
    .result (w_aluResult)
  );

  // Advance the two pipeline stages; reset empties both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1      <= '0;
      r_s2Valid <= 1'b0;
      r_s2      <= '0;
    end else begin
      r_s1Valid <= load_en;
      if (load_en) begin
        r_s1 <= '{opc: opcode, op_a: operand_a, op_b: operand_b, addr: write_pointer};
      end
      r_s2Valid <= r_s1Valid && !w_s1Squash;
      r_s2      <= r_s1;
    end
  end

  // Update the entry storage: writeback from S2, then the new write, which
  // never targets the same entry as a writeback on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_entries[i] <= '0;
      end
      r_valid <= '1;
    end else begin
      if (w_writeback) begin
        r_entries[r_s2.addr].result <= w_aluResult;
        r_valid[r_s2.addr]          <= 1'b1;
      end
      if (load_en) begin
        r_entries[write_pointer] <= '{opc: opcode, op_a: operand_a,
                                      op_b: operand_b, result: '0};
        r_valid[write_pointer]   <= 1'b0;
      end
    end
  end

  assign instruction_word = r_entries[read_pointer];
  assign result_valid     = r_valid[read_pointer];
  assign busy             = r_s1Valid | r_s2Valid;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed self-checking bench for instr_exec_unit.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         load_en;
  operand_t     operand_a;
  operand_t     operand_b;
  opcode_t      opcode;
  address_t     write_pointer;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         result_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;

  instruction_t expWords [32];

  instr_exec_unit #(.NUM_ENTRIES(32), .PIPE_STAGES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result_valid     (result_valid),
    .busy             (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the write-side inputs for the next edge.
  task automatic applyStimulus(input logic en, input address_t wp, input opcode_t op,
                               input operand_t a, input operand_t b);
    load_en       = en;
    write_pointer = wp;
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
  endtask

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [130:0] observed,
                             input logic [130:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Read an entry and check its word and valid bit.
  task automatic checkEntry(input string tag, input address_t addr,
                            input instruction_t expWord, input logic expValid);
    read_pointer = addr;
    #1;
    checkOutput({tag, "_word"}, instruction_word, expWord);
    checkOutput({tag, "_valid"}, result_valid, expValid);
  endtask

  function automatic instruction_t mkWord(opcode_t op, operand_t a, operand_t b, result_t r);
    return '{opc: op, op_a: a, op_b: b, result: r};
  endfunction

  // Reference arithmetic: division done on magnitudes with the sign applied
  // afterwards, so it is independent of the language's signed / and %.
  function automatic result_t refModel(opcode_t op, operand_t a, operand_t b);
    longint la, lb, ma, mb, q, r;
    la = longint'(a);
    lb = longint'(b);
    ma = (la < 0) ? -la : la;
    mb = (lb < 0) ? -lb : lb;
    case (op)
      ZERO:  return 64'sd0;
      PASSA: return la;
      PASSB: return lb;
      ADD:   return la + lb;
      SUB:   return la - lb;
      MULT:  return la * lb;
      DIV: begin
        if (lb == 0) return 64'sd0;
        q = ma / mb;
        return ((la < 0) != (lb < 0)) ? -q : q;
      end
      MOD: begin
        if (lb == 0) return 64'sd0;
        r = ma % mb;
        return (la < 0) ? -r : r;
      end
      default: return 64'sd0;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    read_pointer = '0;
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);

    // Reset state: all entries cleared and valid, nothing in flight.
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      checkEntry($sformatf("reset_e%0d", i), address_t'(i), '0, 1'b1);
    end

    // MULT -7*15 to entry 3, watch result appear two edges later.
    applyStimulus(1'b1, 5'd3, MULT, -32'sd7, 32'sd15);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    checkEntry("mult_N", 5'd3, mkWord(MULT, -32'sd7, 32'sd15, 64'sd0), 1'b0);
    checkOutput("mult_N_busy", busy, 1'b1);
    tick();
    checkEntry("mult_N1", 5'd3, mkWord(MULT, -32'sd7, 32'sd15, 64'sd0), 1'b0);
    checkOutput("mult_N1_busy", busy, 1'b1);
    tick();
    checkEntry("mult_N2", 5'd3, mkWord(MULT, -32'sd7, 32'sd15, -64'sd105), 1'b1);
    checkOutput("mult_N2_busy", busy, 1'b0);

    // Back-to-back DIV / MOD / divide-by-zero.
    applyStimulus(1'b1, 5'd0, DIV, -32'sd9, 32'sd2);
    tick();
    applyStimulus(1'b1, 5'd1, MOD, -32'sd9, 32'sd2);
    tick();
    applyStimulus(1'b1, 5'd2, DIV, 32'sd5, 32'sd0);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    checkOutput("b2b_busy_N2", busy, 1'b1);
    checkEntry("b2b_div_early", 5'd0, mkWord(DIV, -32'sd9, 32'sd2, -64'sd4), 1'b1);
    tick();
    checkOutput("b2b_busy_N3", busy, 1'b1);
    tick();
    checkOutput("b2b_busy_N4", busy, 1'b0);
    checkEntry("b2b_div", 5'd0, mkWord(DIV, -32'sd9, 32'sd2, -64'sd4), 1'b1);
    checkEntry("b2b_mod", 5'd1, mkWord(MOD, -32'sd9, 32'sd2, -64'sd1), 1'b1);
    checkEntry("b2b_div0", 5'd2, mkWord(DIV, 32'sd5, 32'sd0, 64'sd0), 1'b1);

    // Rewrite of entry 5 while the first op sits in S1: only 7 is stored.
    applyStimulus(1'b1, 5'd5, ADD, 32'sd1, 32'sd2);
    tick();
    applyStimulus(1'b1, 5'd5, SUB, 32'sd10, 32'sd3);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    checkEntry("squash_s1_N1", 5'd5, mkWord(SUB, 32'sd10, 32'sd3, 64'sd0), 1'b0);
    tick();
    checkEntry("squash_s1_N2", 5'd5, mkWord(SUB, 32'sd10, 32'sd3, 64'sd0), 1'b0);
    tick();
    checkEntry("squash_s1_N3", 5'd5, mkWord(SUB, 32'sd10, 32'sd3, 64'sd7), 1'b1);
    checkOutput("squash_s1_busy", busy, 1'b0);

    // New write to entry 9 on the same edge as the old op's writeback.
    applyStimulus(1'b1, 5'd9, PASSA, 32'sd11, 32'sd0);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    tick();
    applyStimulus(1'b1, 5'd9, PASSB, 32'sd0, 32'sd22);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    checkEntry("collide_N2", 5'd9, mkWord(PASSB, 32'sd0, 32'sd22, 64'sd0), 1'b0);
    tick();
    checkEntry("collide_N3", 5'd9, mkWord(PASSB, 32'sd0, 32'sd22, 64'sd0), 1'b0);
    tick();
    checkEntry("collide_N4", 5'd9, mkWord(PASSB, 32'sd0, 32'sd22, 64'sd22), 1'b1);

    // Reset in the middle of an op to entry 7; writes during reset ignored.
    applyStimulus(1'b1, 5'd7, PASSA, 32'sd42, 32'sd0);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    tick();
    reset_n = 1'b0;
    #1;
    checkEntry("rst_mid_e7", 5'd7, '0, 1'b1);
    checkEntry("rst_mid_e3", 5'd3, '0, 1'b1);
    checkOutput("rst_mid_busy", busy, 1'b0);
    applyStimulus(1'b1, 5'd8, PASSA, 32'sd99, 32'sd0);
    tick();
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    checkEntry("rst_after_e7", 5'd7, '0, 1'b1);
    checkEntry("rst_ignored_e8", 5'd8, '0, 1'b1);
    checkOutput("rst_after_busy", busy, 1'b0);

    // Back-to-back random ops to entries 0..30 against the reference model.
    for (int i = 0; i < 31; i++) begin
      opcode_t  op;
      operand_t a;
      operand_t b;
      op = opcode_t'($urandom_range(0, 7));
      a  = operand_t'($urandom);
      b  = operand_t'($urandom);
      if ($urandom_range(0, 3) == 0) a = operand_t'($signed($urandom_range(0, 200)) - 100);
      if ($urandom_range(0, 3) == 0) b = operand_t'($signed($urandom_range(0, 20)) - 10);
      expWords[i] = mkWord(op, a, b, refModel(op, a, b));
      applyStimulus(1'b1, address_t'(i), op, a, b);
      tick();
    end
    applyStimulus(1'b0, 5'd0, ZERO, 32'sd0, 32'sd0);
    tick();
    tick();
    checkOutput("rand_busy", busy, 1'b0);
    for (int i = 0; i < 31; i++) begin
      checkEntry($sformatf("rand_e%0d", i), address_t'(i), expWords[i], 1'b1);
    end
    checkEntry("rand_e31_untouched", 5'd31, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
